multi_timer: RTL

Multi-channel programmable interval timer, the parametrised successor to the single-channel 75 µs timer. It provides CHANNELS independent countdown channels sharing one clock. Each channel has its own prescaler phase, so every channel's first interval is exact. Each channel supports stop/abort, a live remaining-count readout and, optionally, periodic auto-reload. It serves the main FPGA's sequencing logic (sensor ping spacing, motor command timeouts) wherever several timeouts run concurrently.

---
 rtl/multi_timer_pkg.sv | 18 +
 rtl/multi_timer_channel.sv | 99 +++++++++
 rtl/multi_timer.sv | 42 ++++
 3 files changed

// File: rtl/multi_timer_pkg.sv
// Shared types and constants for the multi-channel interval timer.
// Channel state encoding, common tick presets and the prescaler width helper.
package multi_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    localparam int TICKS_27MHZ = 2025;
    localparam int TICKS_25MHZ = 1875;

    // A single-cycle tick still needs a one-bit prescaler register.
    function automatic int prescWidth(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One countdown channel: prescaler, remaining counter, state and expiry register.
// Auto-reload support is present only when MULTI_TIMER_RELOAD_EN is defined.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int TICK_CYCLES = TICKS_27MHZ,
    parameter int LEN_W       = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [LEN_W-1:0] i_length,
`ifdef MULTI_TIMER_RELOAD_EN
    input  logic             i_periodic,
`endif
    output logic             o_expired,
    output logic             o_busy,
    output logic [LEN_W-1:0] o_remaining
);

    localparam int            PW         = prescWidth(TICK_CYCLES);
    localparam logic [PW-1:0] LAST_PHASE = PW'(TICK_CYCLES - 1);

    chan_state_e      r_state;
    logic [PW-1:0]    r_presc;
    logic [LEN_W-1:0] r_remaining;
    logic             r_expired;
    logic             w_tick;
`ifdef MULTI_TIMER_RELOAD_EN
    logic [LEN_W-1:0] r_reloadLen;
    logic             r_periodic;
`endif

    assign w_tick = (r_state == RUN) && (r_presc == LAST_PHASE);

    // Stop outranks start, and both outrank a tick due on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_remaining <= '0;
            r_expired   <= 1'b0;
`ifdef MULTI_TIMER_RELOAD_EN
            r_reloadLen <= '0;
            r_periodic  <= 1'b0;
`endif
        end else begin
            r_expired <= 1'b0;
            if (i_stop) begin
                r_state     <= IDLE;
                r_presc     <= '0;
                r_remaining <= '0;
            end else if (i_start) begin
                r_presc     <= '0;
`ifdef MULTI_TIMER_RELOAD_EN
                r_reloadLen <= i_length;
                r_periodic  <= i_periodic;
`endif
                if (i_length == '0) begin
                    // Zero length fires once and never reloads, even in periodic mode.
                    r_expired   <= 1'b1;
                    r_state     <= IDLE;
                    r_remaining <= '0;
                end else begin
                    r_state     <= RUN;
                    r_remaining <= i_length;
                end
            end else if (r_state == RUN) begin
                if (w_tick) begin
                    r_presc <= '0;
                    if (r_remaining == LEN_W'(1)) begin
                        r_expired <= 1'b1;
`ifdef MULTI_TIMER_RELOAD_EN
                        if (r_periodic) begin
                            r_remaining <= r_reloadLen;
                        end else begin
                            r_state     <= IDLE;
                            r_remaining <= '0;
                        end
`else
                        r_state     <= IDLE;
                        r_remaining <= '0;
`endif
                    end else begin
                        r_remaining <= r_remaining - LEN_W'(1);
                    end
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

    assign o_expired   = r_expired;
    assign o_busy      = (r_state == RUN);
    assign o_remaining = r_remaining;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel programmable interval timer: CHANNELS independent countdown channels.
// Define MULTI_TIMER_RELOAD_EN to add the periodic port and auto-reload.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int TICK_CYCLES = TICKS_27MHZ,
    parameter int CHANNELS    = 4,
    parameter int LEN_W       = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS*LEN_W-1:0] length,
`ifdef MULTI_TIMER_RELOAD_EN
    input  logic [CHANNELS-1:0]       periodic,
`endif
    output logic [CHANNELS-1:0]       expired,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS*LEN_W-1:0] remaining
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        timer_channel #(
            .TICK_CYCLES(TICK_CYCLES),
            .LEN_W      (LEN_W)
        ) u_chan (
            .i_clk      (clk),
            .i_reset    (reset),
            .i_start    (start[g]),
            .i_stop     (stop[g]),
            .i_length   (length[g*LEN_W +: LEN_W]),
`ifdef MULTI_TIMER_RELOAD_EN
            .i_periodic (periodic[g]),
`endif
            .o_expired  (expired[g]),
            .o_busy     (busy[g]),
            .o_remaining(remaining[g*LEN_W +: LEN_W])
        );
    end

endmodule
